// File: rtl/mod_adder_pkg.sv
// mod_adder_pkg: datapath widths and FSM state encoding shared by the modular adder.
package mod_adder_pkg;
    localparam int OPW  = 1027;
    localparam int ADDW = 1028;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE1 = 3'd1;
    localparam logic [2:0] WAIT1  = 3'd2;
    localparam logic [2:0] ISSUE2 = 3'd3;
    localparam logic [2:0] WAIT2  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
endpackage

// File: rtl/mod_adder.sv
// mod_adder: (a +/- b) mod M via two passes through an external 1027-bit adder.
// Define MOD_ADDER_EARLY_EXIT_EN to skip the correction pass for non-negative differences.
module mod_adder
    import mod_adder_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            subtract,
    input  logic [OPW-1:0]  in_a,
    input  logic [OPW-1:0]  in_b,
    input  logic [OPW-1:0]  in_m,
    output logic [OPW-1:0]  result,
    output logic            done,
    output logic            busy,
    output logic            add_start,
    output logic            add_subtract,
    output logic [OPW-1:0]  add_in_a,
    output logic [OPW-1:0]  add_in_b,
    input  logic [ADDW-1:0] add_result,
    input  logic            add_done
);
    logic [2:0]      state_q, state_d;
    logic [OPW-1:0]  a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
    logic [ADDW-1:0] r1_q, r1_d;
    logic            sub_q, sub_d;
    logic            op1, op2, take_sum;

    assign op1 = (state_q == ISSUE1) || (state_q == WAIT1);
    assign op2 = (state_q == ISSUE2) || (state_q == WAIT2);
    // Second pass keeps the corrected value when a+b-M did not borrow or a-b went negative
    assign take_sum = sub_q ? r1_q[ADDW-1] : !add_result[ADDW-1];

    assign add_start    = (state_q == ISSUE1) || (state_q == ISSUE2);
    assign add_subtract = op1 ? sub_q : (op2 && !sub_q);
    assign add_in_a     = op1 ? a_q : op2 ? r1_q[OPW-1:0] : '0;
    assign add_in_b     = op1 ? b_q : op2 ? m_q : '0;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign result       = res_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        sub_d   = sub_q;
        r1_d    = r1_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE1;
                a_d     = in_a;
                b_d     = in_b;
                m_d     = in_m;
                sub_d   = subtract;
            end
            ISSUE1: state_d = WAIT1;
            WAIT1: if (add_done) begin
                r1_d = add_result;
`ifdef MOD_ADDER_EARLY_EXIT_EN
                if (sub_q && !add_result[ADDW-1]) begin
                    state_d = DONE;
                    res_d   = add_result[OPW-1:0];
                end else begin
                    state_d = ISSUE2;
                end
`else
                state_d = ISSUE2;
`endif
            end
            ISSUE2: state_d = WAIT2;
            WAIT2: if (add_done) begin
                state_d = DONE;
                res_d   = take_sum ? add_result[OPW-1:0] : r1_q[OPW-1:0];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            sub_q   <= 1'b0;
            r1_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            sub_q   <= sub_d;
            r1_q    <= r1_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_mod_adder.sv
// tb_mod_adder: directed vectors for mod_adder with a behavioural external adder.
module tb_mod_adder;
    typedef logic [1026:0] opnd_t;
    localparam int LAT = 2;
`ifdef MOD_ADDER_EARLY_EXIT_EN
    localparam int SUB_NOWRAP_STARTS = 1;
`else
    localparam int SUB_NOWRAP_STARTS = 2;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          subtract = 1'b0;
    opnd_t         in_a = '0, in_b = '0, in_m = '0;
    opnd_t         result, add_in_a, add_in_b;
    logic          done, busy, add_start, add_subtract;
    logic [1027:0] add_result = '0;
    logic          add_done;
    logic          mdl_done = 1'b0;
    logic          inj_done = 1'b0;
    int            starts = 0;
    int            checks = 0;
    int            errors = 0;

    assign add_done = mdl_done | inj_done;

    mod_adder dut (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done),
        .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
        .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result),
        .add_done(add_done)
    );

    always #5 clk = ~clk;

    // External adder: accepts add_start, answers LAT cycles later, blind to resetn
    initial begin
        int cnt;
        logic [1027:0] res;
        cnt = 0;
        res = '0;
        forever begin
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mdl_done   = 1'b1;
                    add_result = res;
                end
            end else if (add_start) begin
                res = add_subtract ? {1'b0, add_in_a} - {1'b0, add_in_b}
                                   : {1'b0, add_in_a} + {1'b0, add_in_b};
                cnt = LAT;
                starts++;
            end
        end
    end

    task automatic chk(input string tag, input opnd_t got, input opnd_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    task automatic run(input string tag, input logic s, input opnd_t a, input opnd_t b,
                       input opnd_t m, input opnd_t exp, input int exp_starts, input logic hold);
        int s0, dn;
        logic seen;
        opnd_t got;
        s0 = starts;
        dn = 0;
        seen = 1'b0;
        got = '0;
        start = 1'b1;
        subtract = s;
        in_a = a;
        in_b = b;
        in_m = m;
        @(posedge clk);
        #1;
        if (hold) begin
            in_a = 1;
            in_b = 1;
            subtract = ~s;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                dn++;
                got = result;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_seen"}, opnd_t'(seen), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk({tag, "_res"}, got, exp);
        chk({tag, "_held"}, result, exp);
        chk({tag, "_starts"}, opnd_t'(starts - s0), opnd_t'(exp_starts));
        chk({tag, "_dones"}, opnd_t'(dn), 1);
    endtask

    initial begin
        opnd_t big;
        logic flag;
        #1;
        chk("rst_busy", opnd_t'(busy), 0);
        chk("rst_done", opnd_t'(done), 0);
        chk("rst_astart", opnd_t'(add_start), 0);
        chk("rst_result", result, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run("add_wrap", 1'b0, 5, 7, 11, 1, 2, 1'b0);
        run("add_nowrap", 1'b0, 3, 4, 11, 7, 2, 1'b0);
        run("sub_wrap", 1'b1, 3, 7, 11, 7, 2, 1'b0);
        run("sub_nowrap", 1'b1, 9, 2, 11, 7, SUB_NOWRAP_STARTS, 1'b0);
        big = '0;
        big[1026] = 1'b1;
        big = big - 1;
        run("add_bound", 1'b0, big - 1, big - 1, big, big - 2, 2, 1'b0);
        run("hold_start", 1'b0, 5, 7, 11, 1, 2, 1'b1);

        inj_done = 1'b1;
        @(posedge clk);
        #1;
        inj_done = 1'b0;
        chk("stray_busy", opnd_t'(busy), 0);
        @(posedge clk);
        #1;
        chk("stray_busy2", opnd_t'(busy | done), 0);
        run("after_stray", 1'b0, 3, 4, 11, 7, 2, 1'b0);

        start = 1'b1;
        subtract = 1'b0;
        in_a = 5;
        in_b = 7;
        in_m = 11;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("wait1_busy", opnd_t'(busy), 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_busy", opnd_t'(busy), 0);
        chk("arst_done", opnd_t'(done), 0);
        chk("arst_astart", opnd_t'(add_start), 0);
        chk("arst_result", result, 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            flag = flag | busy | done | add_start;
        end
        chk("late_done_ignored", opnd_t'(flag), 0);
        run("post_reset", 1'b0, 1, 1, 11, 2, 2, 1'b0);
`ifdef MOD_ADDER_EARLY_EXIT_EN
        run("early_wrap", 1'b1, 3, 7, 11, 7, 2, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_adder.md
MOD_ADDER -- requirements
Module: mod_adder

Interface
REQ-001 Parameters SHALL be: none. Operand width is fixed at 1027 bits to match the multi-precision adder datapath.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 subtract  input  1  0 = (a+b) mod M, 1 = (a-b) mod M; sampled with start.
REQ-006 in_a, in_b, in_m  input  1027 each  operands and modulus; sampled with start.
REQ-007 result  output  1027  modular result; valid while done=1 and held until the next accepted start.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-010 add_start  output  1  one-cycle request to the external 1027-bit multi-precision adder.
REQ-011 add_subtract, add_in_a, add_in_b  output  1/1027/1027  adder operation and operands.
REQ-012 add_result  input  1028  adder sum or difference; bit 1027 is the sign/borrow bit in subtract mode.
REQ-013 add_done  input  1  adder one-cycle completion pulse.

Function
REQ-014 The block SHALL be the initiator of the adder start/done handshake. It SHALL NOT instantiate the adder.
REQ-015 FSM states SHALL be: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- IDLE to ISSUE1 on start, capturing in_a, in_b, in_m and subtract into registers.
- ISSUE1 to WAIT1, and ISSUE2 to WAIT2, after exactly one cycle.
- WAIT1 to ISSUE2 on add_done.
- WAIT2 to DONE on add_done.
- DONE to IDLE after one cycle.
REQ-016 add_start SHALL be 1 only in ISSUE1 and ISSUE2.
REQ-017 add_subtract, add_in_a and add_in_b SHALL be valid in the ISSUE cycle and held stable until the matching add_done.
REQ-018 Operation 1 SHALL be a+b when subtract=0 and a-b when subtract=1. On add_done, add_result SHALL be latched into an internal 1028-bit register r1.
REQ-019 Add mode, operation 2: r1[1026:0] - M. On add_done, if add_result[1027]=0, result SHALL be add_result[1026:0]; otherwise result SHALL be r1[1026:0].
REQ-020 Subtract mode, operation 2: r1[1026:0] + M. On add_done, if r1[1027]=1, result SHALL be add_result[1026:0]; otherwise result SHALL be r1[1026:0].
REQ-021 The block SHALL always issue exactly two adder operations per request (constant time), unless the macro in REQ-030 is defined.
REQ-022 done SHALL be 1 only in the DONE state, which is the cycle after the second add_done.
REQ-023 Precondition: in_m[1026]=0, in_a < in_m and in_b < in_m. Results for inputs outside this range are unspecified, but the FSM SHALL still terminate.
REQ-024 start outside IDLE SHALL be ignored, with no effect on the captured operands.
REQ-025 add_done outside WAIT1/WAIT2 SHALL be ignored.
REQ-026 start and add_done arriving in the same cycle SHALL be handled independently per the state rules above.

Reset
REQ-027 While resetn=0, the FSM SHALL be forced to IDLE immediately, without waiting for a clock edge.
REQ-028 While resetn=0, all outputs and all internal registers SHALL be 0, including mid-operation.
REQ-029 The first accepted start after reset SHALL complete normally. Any add_done still in flight from the aborted operation SHALL be ignored per REQ-025.

Configuration
REQ-030 Macro MOD_ADDER_EARLY_EXIT_EN.
- Defined: in subtract mode, when r1[1027]=0, WAIT1 SHALL go directly to DONE with result = r1[1026:0] and no second add_start.
- Undefined: REQ-021 applies.

Structure
REQ-031 A shared package SHALL hold: the operand-width constant (1027), the adder-width constant (1028) and the FSM state encoding.
REQ-032 No sub-module. FSM, operand registers and result selection SHALL be inline. The parent SHALL connect the adder.

Verification
REQ-033 Add with wrap: subtract=0, a=5, b=7, M=11 -> result=1, exactly two add_start pulses, one done pulse.
REQ-034 Add without wrap: a=3, b=4, M=11 -> result=7. Sub with wrap: a=3, b=7, M=11 -> result=7. Sub without wrap: a=9, b=2 -> result=7 with two add_start pulses (macro undefined).
REQ-035 Add at the boundary: M=2^1026-1, a=b=M-1 -> result=M-2.
REQ-036 start re-asserted every cycle while busy -> exactly one done pulse and the first request's result. add_done injected in IDLE -> no state change.
REQ-037 resetn pulsed low in WAIT1 -> busy, done and add_start are 0 within the reset cycle. A late add_done is ignored. The next request (a=1, b=1, M=11) returns 2.
REQ-038 With MOD_ADDER_EARLY_EXIT_EN defined: sub a=9, b=2, M=11 -> result=7 after a single add_start. Sub a=3, b=7 -> two add_start pulses and result=7.
